// File: rtl/pe_sched_pkg.sv
// Shared state encoding, mode encoding and default sizing for the PE-array scheduler.
package pe_sched_pkg;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DATA_PRE = 3'd1,
    ST_DS_SCAN  = 3'd2,
    ST_FS_SCAN  = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic MODE_DS     = 1'b0;
  localparam logic MODE_HYBRID = 1'b1;

  localparam int ROW_W = 7;

  localparam int DEF_NUM_CB      = 4;
  localparam int DEF_NUM_COLS    = 32;
  localparam int DEF_PRE_CYCLES  = 64;
  localparam int DEF_DS_ROWS     = 38;
  localparam int DEF_DS_PRELOAD  = 8;
  localparam int DEF_FS_ROWS     = 21;
  localparam int DEF_FS_REF_ROWS = 4;
  localparam int DEF_FS_COL_LO   = 8;
  localparam int DEF_FS_COL_HI   = 23;
endpackage

// File: rtl/pe_sched_decode.sv
// Combinational map from (state, pass, row) to the SAD/reference steering controls.
module pe_sched_decode
  import pe_sched_pkg::*;
#(
  parameter int NUM_CB      = DEF_NUM_CB,
  parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
  parameter int DS_ROWS     = DEF_DS_ROWS,
  parameter int DS_PRELOAD  = DEF_DS_PRELOAD,
  parameter int FS_REF_ROWS = DEF_FS_REF_ROWS
) (
  input  state_e                      state,
  input  logic [$clog2(NUM_CB)-1:0]   pass,
  input  logic [ROW_W-1:0]            row,
  output logic [$clog2(NUM_CB)-1:0]   abs_control,
  output logic                        change_ref,
  output logic                        ref_input_control,
  output logic                        cb_select
);
  localparam int AW = $clog2(NUM_CB);
  localparam logic [ROW_W-1:0] PRE_HALF  = ROW_W'(PRE_CYCLES / 2);
  localparam logic [ROW_W-1:0] DS_PRE_R  = ROW_W'(DS_PRELOAD);
  localparam logic [ROW_W-1:0] DS_TAIL_R = ROW_W'(DS_ROWS - 4);
  localparam logic [ROW_W-1:0] FS_REF_R  = ROW_W'(FS_REF_ROWS);

  logic [AW-1:0] ds_even;
  logic [AW-1:0] ds_odd;

  // Down-sampled passes alternate between sub-block 2p and its partner 2p+1.
  assign ds_even = AW'({pass, 1'b0});
  assign ds_odd  = AW'({pass, 1'b1});

  always_comb begin
    abs_control       = '0;
    change_ref        = 1'b0;
    ref_input_control = 1'b0;
    cb_select         = 1'b1;
    unique case (state)
      ST_DATA_PRE: cb_select = (row < PRE_HALF);
      ST_DS_SCAN: begin
        cb_select         = (pass == '0);
        ref_input_control = 1'b1;
        if (row < DS_PRE_R) begin
          abs_control = ds_even;
          change_ref  = 1'b1;
        end else if (row < DS_TAIL_R) begin
          abs_control = row[0] ? ds_even : ds_odd;
          change_ref  = row[0];
        end else begin
          abs_control = ds_odd;
          change_ref  = 1'b1;
        end
      end
      ST_FS_SCAN: begin
        abs_control       = pass;
        cb_select         = 1'b0;
        change_ref        = 1'b1;
        ref_input_control = (row < FS_REF_R);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/pe_array_sched.sv
// Per-CU scheduler: preload, then per-column down-sampled or full-sample scans, then a done pulse.
module pe_array_sched
  import pe_sched_pkg::*;
#(
  parameter int NUM_CB      = DEF_NUM_CB,
  parameter int NUM_COLS    = DEF_NUM_COLS,
  parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
  parameter int DS_ROWS     = DEF_DS_ROWS,
  parameter int DS_PRELOAD  = DEF_DS_PRELOAD,
  parameter int FS_ROWS     = DEF_FS_ROWS,
  parameter int FS_REF_ROWS = DEF_FS_REF_ROWS,
  parameter int FS_COL_LO   = DEF_FS_COL_LO,
  parameter int FS_COL_HI   = DEF_FS_COL_HI
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mode,
  input  logic                          abort,
  input  logic                          ref_valid,
  output logic                          in_curr_enable,
  output logic                          cb_select,
  output logic [$clog2(NUM_CB)-1:0]     abs_control,
  output logic                          change_ref,
  output logic                          ref_input_control,
  output logic                          pe_en,
  output logic [$clog2(NUM_COLS):0]     search_column_count,
  output logic [ROW_W-1:0]              search_row_count,
  output logic                          busy,
  output logic                          done
);
  localparam int AW = $clog2(NUM_CB);
  localparam int CW = $clog2(NUM_COLS) + 1;
  localparam logic [ROW_W-1:0] PRE_LAST = ROW_W'(PRE_CYCLES - 1);
  localparam logic [ROW_W-1:0] DS_LAST  = ROW_W'(DS_ROWS - 1);
  localparam logic [ROW_W-1:0] FS_LAST  = ROW_W'(FS_ROWS - 1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [AW-1:0]    pass_q, pass_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CW-1:0]    col_q, col_d;

  logic             in_curr_enable_q, in_curr_enable_d;
  logic             cb_select_q, cb_select_d;
  logic [AW-1:0]    abs_control_q, abs_control_d;
  logic             change_ref_q, change_ref_d;
  logic             ref_input_control_q, ref_input_control_d;
  logic             pe_en_q, pe_en_d;
  logic [CW-1:0]    search_column_count_q, search_column_count_d;
  logic [ROW_W-1:0] search_row_count_q, search_row_count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [AW-1:0]    dec_abs;
  logic             dec_chg, dec_ric, dec_cb;
  logic             is_scan, last_row, last_pass, last_col;
  logic [CW-1:0]    col_inc;

  pe_sched_decode #(
    .NUM_CB(NUM_CB), .PRE_CYCLES(PRE_CYCLES), .DS_ROWS(DS_ROWS),
    .DS_PRELOAD(DS_PRELOAD), .FS_REF_ROWS(FS_REF_ROWS)
  ) u_decode (
    .state(state_q), .pass(pass_q), .row(row_q),
    .abs_control(dec_abs), .change_ref(dec_chg),
    .ref_input_control(dec_ric), .cb_select(dec_cb)
  );

  function automatic state_e col_kind(input logic [CW-1:0] col, input logic m);
    return (m == MODE_HYBRID && col >= CW'(FS_COL_LO) && col <= CW'(FS_COL_HI))
           ? ST_FS_SCAN : ST_DS_SCAN;
  endfunction

  assign is_scan   = (state_q == ST_DS_SCAN) || (state_q == ST_FS_SCAN);
  assign last_row  = row_q == ((state_q == ST_FS_SCAN) ? FS_LAST : DS_LAST);
  assign last_pass = pass_q == ((state_q == ST_FS_SCAN) ? AW'(NUM_CB - 1) : AW'(1));
  assign last_col  = col_q == CW'(NUM_COLS - 1);
  assign col_inc   = col_q + 1'b1;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pass_d  = pass_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_DATA_PRE;
        mode_d  = mode;
        pass_d  = '0;
        row_d   = '0;
        col_d   = '0;
      end
      // The row counter doubles as the preload cycle counter.
      ST_DATA_PRE: if (row_q == PRE_LAST) begin
        row_d   = '0;
        state_d = col_kind('0, mode_q);
      end else begin
        row_d = row_q + 1'b1;
      end
      ST_DS_SCAN, ST_FS_SCAN: if (ref_valid) begin
        if (!last_row) begin
          row_d = row_q + 1'b1;
        end else begin
          row_d = '0;
          if (!last_pass) begin
            pass_d = pass_q + 1'b1;
          end else begin
            pass_d  = '0;
            col_d   = col_inc;
            state_d = last_col ? ST_DONE : col_kind(col_inc, mode_q);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        col_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      pass_d  = '0;
      row_d   = '0;
      col_d   = '0;
    end
  end

  // Output stage describes the row presented this cycle; a stalled row shows pe_en=0.
  always_comb begin
    in_curr_enable_d      = (state_q == ST_DATA_PRE);
    cb_select_d           = dec_cb;
    abs_control_d         = dec_abs;
    change_ref_d          = dec_chg && ref_valid;
    ref_input_control_d   = dec_ric;
    pe_en_d               = is_scan && ref_valid;
    search_row_count_d    = is_scan ? row_q : '0;
    search_column_count_d = (is_scan || state_q == ST_DONE) ? col_q : '0;
    busy_d                = (state_q != ST_IDLE);
    done_d                = (state_q == ST_DONE);
    if (abort) begin
      in_curr_enable_d      = 1'b0;
      cb_select_d           = 1'b1;
      abs_control_d         = '0;
      change_ref_d          = 1'b0;
      ref_input_control_d   = 1'b0;
      pe_en_d               = 1'b0;
      search_row_count_d    = '0;
      search_column_count_d = '0;
      busy_d                = 1'b0;
      done_d                = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= ST_IDLE;
      mode_q                <= MODE_DS;
      pass_q                <= '0;
      row_q                 <= '0;
      col_q                 <= '0;
      in_curr_enable_q      <= 1'b0;
      cb_select_q           <= 1'b1;
      abs_control_q         <= '0;
      change_ref_q          <= 1'b0;
      ref_input_control_q   <= 1'b0;
      pe_en_q               <= 1'b0;
      search_column_count_q <= '0;
      search_row_count_q    <= '0;
      busy_q                <= 1'b0;
      done_q                <= 1'b0;
    end else begin
      state_q               <= state_d;
      mode_q                <= mode_d;
      pass_q                <= pass_d;
      row_q                 <= row_d;
      col_q                 <= col_d;
      in_curr_enable_q      <= in_curr_enable_d;
      cb_select_q           <= cb_select_d;
      abs_control_q         <= abs_control_d;
      change_ref_q          <= change_ref_d;
      ref_input_control_q   <= ref_input_control_d;
      pe_en_q               <= pe_en_d;
      search_column_count_q <= search_column_count_d;
      search_row_count_q    <= search_row_count_d;
      busy_q                <= busy_d;
      done_q                <= done_d;
    end
  end

  assign in_curr_enable      = in_curr_enable_q;
  assign cb_select           = cb_select_q;
  assign abs_control         = abs_control_q;
  assign change_ref          = change_ref_q;
  assign ref_input_control   = ref_input_control_q;
  assign pe_en               = pe_en_q;
  assign search_column_count = search_column_count_q;
  assign search_row_count    = search_row_count_q;
  assign busy                = busy_q;
  assign done                = done_q;
endmodule

// File: tb/tb_pe_array_sched.sv
// Drives a default instance and an 8-sub-block/16-column instance with shared stimulus and
// compares every cycle against a queue of expected issue slots built from the row rules.
module tb_pe_array_sched;
  localparam int PRE = 64, DSR = 38, DSP = 8, FSR = 21, FSREF = 4, LO = 8, HI = 23;

  typedef struct {
    bit ice, cb, chg, ric, pe, busy, dn;
    int abs, col, row;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, mode, abort, ref_valid;

  logic       ice0, cb0, chg0, ric0, pe0, busy0, done0;
  logic [1:0] abs0;
  logic [5:0] col0;
  logic [6:0] row0;
  logic       ice1, cb1, chg1, ric1, pe1, busy1, done1;
  logic [2:0] abs1;
  logic [4:0] col1;
  logic [6:0] row1;

  exp_t obs0, obs1;
  exp_t exp_q[2][$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  int   t_pre, t_done, max_abs1;
  bit   pre_seen;

  always #5 clk = ~clk;

  pe_array_sched dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .ref_valid(ref_valid),
    .in_curr_enable(ice0), .cb_select(cb0), .abs_control(abs0), .change_ref(chg0),
    .ref_input_control(ric0), .pe_en(pe0), .search_column_count(col0),
    .search_row_count(row0), .busy(busy0), .done(done0)
  );

  pe_array_sched #(.NUM_CB(8), .NUM_COLS(16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .ref_valid(ref_valid),
    .in_curr_enable(ice1), .cb_select(cb1), .abs_control(abs1), .change_ref(chg1),
    .ref_input_control(ric1), .pe_en(pe1), .search_column_count(col1),
    .search_row_count(row1), .busy(busy1), .done(done1)
  );

  always_comb begin
    obs0.ice = ice0; obs0.cb = cb0; obs0.chg = chg0; obs0.ric = ric0;
    obs0.pe = pe0; obs0.busy = busy0; obs0.dn = done0;
    obs0.abs = int'(abs0); obs0.col = int'(col0); obs0.row = int'(row0);
    obs1.ice = ice1; obs1.cb = cb1; obs1.chg = chg1; obs1.ric = ric1;
    obs1.pe = pe1; obs1.busy = busy1; obs1.dn = done1;
    obs1.abs = int'(abs1); obs1.col = int'(col1); obs1.row = int'(row1);
  end

  task automatic chk(input string tag, input int got, input int expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e = '{ice: 0, cb: 1, chg: 0, ric: 0, pe: 0, busy: 0, dn: 0, abs: 0, col: 0, row: 0};
    return e;
  endfunction

  function automatic exp_t slot(input bit cb, input int abs, input bit chg, input bit ric,
                                input int col, input int row);
    exp_t e;
    e = '{ice: 0, cb: cb, chg: chg, ric: ric, pe: 1, busy: 1, dn: 0, abs: abs, col: col, row: row};
    return e;
  endfunction

  // Whole CU laid out as one entry per issued cycle: preload, every row of every pass, done.
  task automatic build(input int k, input bit m);
    int ncb   = (k == 0) ? 4 : 8;
    int ncols = (k == 0) ? 32 : 16;
    exp_t e;
    for (int i = 0; i < PRE; i++) begin
      e = idle_e(); e.busy = 1; e.ice = 1; e.cb = (i < PRE / 2);
      exp_q[k].push_back(e);
    end
    for (int c = 0; c < ncols; c++) begin
      if (m && c >= LO && c <= HI) begin
        for (int p = 0; p < ncb; p++)
          for (int r = 0; r < FSR; r++)
            exp_q[k].push_back(slot(0, p, 1, r < FSREF, c, r));
      end else begin
        for (int p = 0; p < 2; p++)
          for (int r = 0; r < DSR; r++) begin
            if (r < DSP)           e = slot(p == 0, 2 * p, 1, 1, c, r);
            else if (r < DSR - 4)  e = slot(p == 0, (r % 2 == 0) ? 2 * p + 1 : 2 * p, r % 2 == 1, 1, c, r);
            else                   e = slot(p == 0, 2 * p + 1, 1, 1, c, r);
            exp_q[k].push_back(e);
          end
      end
    end
    e = idle_e(); e.busy = 1; e.dn = 1; e.col = ncols;
    exp_q[k].push_back(e);
  endtask

  task automatic model_step(input int k, output exp_t e);
    if (rst || abort) begin
      exp_q[k].delete();
      e = idle_e();
    end else if (exp_q[k].size() == 0) begin
      e = idle_e();
      if (start) build(k, mode);
    end else begin
      e = exp_q[k][0];
      if (e.pe && !ref_valid) begin
        e.pe = 0; e.chg = 0;
      end else begin
        void'(exp_q[k].pop_front());
      end
    end
  endtask

  task automatic cmp(input int k, input exp_t o, input exp_t e);
    string p = $sformatf("d%0d.", k);
    chk({p, "busy"}, int'(o.busy), int'(e.busy));
    chk({p, "done"}, int'(o.dn), int'(e.dn));
    chk({p, "in_curr_enable"}, int'(o.ice), int'(e.ice));
    chk({p, "cb_select"}, int'(o.cb), int'(e.cb));
    chk({p, "abs_control"}, o.abs, e.abs);
    chk({p, "change_ref"}, int'(o.chg), int'(e.chg));
    chk({p, "ref_input_control"}, int'(o.ric), int'(e.ric));
    chk({p, "pe_en"}, int'(o.pe), int'(e.pe));
    chk({p, "col_count"}, o.col, e.col);
    chk({p, "row_count"}, o.row, e.row);
  endtask

  task automatic tick();
    exp_t e0, e1;
    @(posedge clk);
    model_step(0, e0);
    model_step(1, e1);
    #1;
    cyc++;
    cmp(0, obs0, e0);
    cmp(1, obs1, e1);
    if (obs0.ice && !pre_seen) begin pre_seen = 1; t_pre = cyc; end
    if (obs0.dn) t_done = cyc;
    if (obs1.pe && obs1.abs > max_abs1) max_abs1 = obs1.abs;
  endtask

  task automatic run_cu(input bit m, input int stall_at, input int stall_len,
                        input int exp_len, input string name);
    int k;
    pre_seen = 0; t_pre = 0; t_done = -1; max_abs1 = 0;
    rst = 0; abort = 0; mode = m; start = 1; ref_valid = 1;
    tick();
    start = 0;
    k = 1;
    for (int n = 0; n < 4000 && t_done < 0; n++) begin
      mode = 1'($urandom);
      ref_valid = !(k > stall_at && k <= stall_at + stall_len);
      tick();
      k++;
    end
    ref_valid = 1;
    tick();
    chk({name, ".runtime"}, t_done - t_pre, exp_len);
    $display("run %s: mode=%0d runtime=%0d", name, m, t_done - t_pre);
  endtask

  task automatic wait_col(input int col, output bit hit);
    hit = 0;
    for (int n = 0; n < 3000 && !hit; n++) begin
      tick();
      hit = (obs0.col == col) && obs0.pe;
    end
  endtask

  initial begin
    bit hit;
    rst = 1; start = 1; mode = 0; abort = 0; ref_valid = 1;
    repeat (3) tick();
    rst = 0; start = 0;
    tick();

    run_cu(0, -10, 0, 2496, "ds_only");
    run_cu(1, -10, 0, 2624, "hybrid");
    run_cu(0, 302, 5, 2501, "ds_stall5");

    // Abort in the middle of column 12, then restart from column 0.
    mode = 1; start = 1; tick(); start = 0;
    wait_col(12, hit);
    chk("abort.reached_col12", int'(hit), 1);
    abort = 1; tick(); abort = 0;
    chk("abort.busy", int'(busy0), 0);
    chk("abort.done", int'(done0), 0);
    run_cu(0, -10, 0, 2496, "after_abort");

    // Reset inside a full-sample column, then a fresh hybrid CU on both instances.
    mode = 1; start = 1; tick(); start = 0;
    wait_col(10, hit);
    chk("rst.reached_col10", int'(hit), 1);
    rst = 1; repeat (2) tick(); rst = 0;
    run_cu(1, -10, 0, 2624, "after_rst");
    chk("d1.max_abs_control", max_abs1, 7);

    for (int n = 0; n < 6000; n++) begin
      rst       = ($urandom_range(2999, 0) == 0);
      abort     = ($urandom_range(799, 0) == 0);
      start     = ($urandom_range(19, 0) == 0);
      mode      = 1'($urandom);
      ref_valid = ($urandom_range(4, 0) != 0);
      tick();
    end
    $display("run random: %0d cycles", 6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
